hit_grader: RTL and testbench
=============================

# hit_grader

Timing judge between the keyboard front end and the player/score logic. It takes one-cycle key events and the two lane positions from the enemy script, and decides whether each press lands inside the hit window. It emits one-cycle hit and miss pulses, a per-event grade and a running combo count. It replaces plain position-equality judging and feeds `player` (life/money) and the enemy sprites (`hit_0`/`hit_1`).

## Interface
Parameters:
- `HIT_POS`, 5'd24, lane position of the hit line.
- `GOOD_WIN`, 2, half-width of the GOOD window; the window is [HIT_POS-GOOD_WIN, HIT_POS+GOOD_WIN].
- `KEY_0`, 9'h023, scancode for lane 0.
- `KEY_1`, 9'h042, scancode for lane 1.
- `COMBO_MAX`, 7'd99, combo saturation value.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `active`  in  1  high while the game is in a play state; low forces idle.
- `key_evt`  in  1  one-cycle pulse (op_ready & op_keydown).
- `last_change`  in  9  scancode qualified by `key_evt`.
- `pos_0`, `pos_1`  in  5 each  enemy positions; 0 means no enemy; the enemy advances by increasing value.
- `hit_0`, `hit_1`  out  1 each  one-cycle hit pulses.
- `miss`  out  1  one-cycle pulse when an enemy leaves the window unhit.
- `grade`  out  2  last event grade: 0 NONE, 1 MISS, 2 GOOD, 3 PERFECT.
- `combo`  out  7  consecutive hits, saturating.

## Operation
- Each lane runs an independent FSM with states IDLE, ARMED and LOCKED.
- IDLE → ARMED: the registered position `pos_q` is nonzero and inside the window.
- ARMED, key event with the matching scancode:
  - Pulse `hit_x`.
  - Grade is PERFECT if `pos_q==HIT_POS`, otherwise GOOD.
  - `combo` increments, saturating at COMBO_MAX.
  - Go to LOCKED.
- ARMED, `pos_q` leaves the window (greater than HIT_POS+GOOD_WIN, or 0):
  - Pulse `miss`, grade MISS, `combo`←0.
  - Go to IDLE.
- LOCKED → IDLE: `pos_q` leaves the window. No miss is raised. Exactly one hit is counted per enemy pass.
- A key press in IDLE or LOCKED, or a non-lane scancode, has no effect. There is no penalty for empty presses.
- If the position jumps directly from below the window to past it, the lane never arms and no miss is raised.
- Simultaneous events in one cycle:
  - Hit on one lane and miss on the other: both pulses fire, grade = MISS, `combo`←1.
  - Two misses: a single `miss` pulse.
  - Two hits cannot occur, because `key_evt` carries one scancode.
- Arithmetic:
  - Window bounds are computed at 6 bits so HIT_POS-GOOD_WIN cannot underflow.
  - Window bounds clamp to 1..31.
- `active` low:
  - All lanes go to IDLE and all pulses are suppressed.
  - `combo`←0 and `grade`←NONE.

## Timing
- Reset values: both lanes IDLE; `hit_0`=`hit_1`=`miss`=0; `grade`=0; `combo`=0; `pos_q`=0.
- Key event in cycle N → `hit_x`, `grade` and `combo` update at N+1.
- Positions are registered once into `pos_q`; they come from clk_22 logic and change slowly. A window exit at cycle N → `miss` at N+2.
- All pulses are exactly one `clk` wide. `grade` holds until the next event.
- Reset asserted mid-pass: everything returns to reset values. After release, an enemy already inside the window re-arms and can still be hit.

## Configuration
- `HIT_GRADER_COMBO_EN` defined: combo counter and saturation logic are present.
- Not defined: `combo` is tied to 0 and no combo register exists. Hit, miss and grade behaviour is unchanged.

## Structure
- Package `hit_grader_pkg`:
  - grade enum (NONE/MISS/GOOD/PERFECT).
  - lane state enum (IDLE/ARMED/LOCKED).
  - window-check function.
- Sub-module `hit_lane`: one per-lane FSM with position register, instantiated twice. Its outputs are hit, miss and perfect.
- The top level merges the lanes and handles grade priority and the combo counter.

## Test plan
- Lane 0: `pos_0` steps 20→24, `key_evt` with 9'h023 at pos 24 → `hit_0` pulses one cycle later, grade=3, combo=1.
- `pos_0`=23, press 9'h023 twice → one `hit_0` only, grade=2, second press ignored (LOCKED).
- `pos_1` steps 22→27 with no press → `miss` pulses once at exit, grade=1, combo=0.
- Reach combo=99, then one more hit → combo stays 99. Compile without `HIT_GRADER_COMBO_EN` → combo always 0.
- Same cycle: lane 0 hit and lane 1 exits unhit → `hit_0`=1, `miss`=1, grade=1, combo=1.
- `active` dropped while lane 1 is ARMED with combo=5 → no pulses, combo=0, grade=0. Assert `rst` mid-pass → all outputs 0.

Source files
------------

// File: rtl/hit_grader_pkg.sv
// Shared types and the hit-window test for the hit grader.
// Grades, lane FSM states and the clamped window check live here.
package hit_grader_pkg;

  localparam int POS_W   = 5;
  localparam int CODE_W  = 9;
  localparam int COMBO_W = 7;

  typedef enum logic [1:0] {
    GRADE_NONE    = 2'd0,
    GRADE_MISS    = 2'd1,
    GRADE_GOOD    = 2'd2,
    GRADE_PERFECT = 2'd3
  } grade_t;

  typedef enum logic [1:0] {
    LANE_IDLE   = 2'd0,
    LANE_ARMED  = 2'd1,
    LANE_LOCKED = 2'd2
  } lane_state_t;

  // Bounds are formed at 6 bits and clamped to 1..31; position 0 means "no enemy".
  function automatic logic in_window(input logic [POS_W-1:0] pos,
                                     input logic [POS_W-1:0] hit_pos,
                                     input logic [POS_W-1:0] good_win);
    logic [POS_W:0] lo;
    logic [POS_W:0] hi;
    if (good_win >= hit_pos)
      lo = 6'd1;
    else
      lo = {1'b0, hit_pos} - {1'b0, good_win};
    hi = {1'b0, hit_pos} + {1'b0, good_win};
    if (hi > 6'd31)
      hi = 6'd31;
    return (pos != '0) && ({1'b0, pos} >= lo) && ({1'b0, pos} <= hi);
  endfunction

endpackage

// File: rtl/hit_grader_lane.sv
// One lane of the grader: registers the enemy position and tracks the pass
// through the hit window. hit/miss/perfect are same-cycle events; the top registers them.
module hit_lane
  import hit_grader_pkg::*;
#(
  parameter logic [POS_W-1:0]  HIT_POS  = 5'd24,
  parameter logic [POS_W-1:0]  GOOD_WIN = 5'd2,
  parameter logic [CODE_W-1:0] KEY      = 9'h023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic              key_evt,
  input  logic [CODE_W-1:0] last_change,
  input  logic [POS_W-1:0]  pos,
  output logic              hit,
  output logic              miss,
  output logic              perfect
);

  logic [POS_W-1:0] pos_q;
  lane_state_t      state_reg;
  logic             in_win;
  logic             key_match;

  assign in_win    = in_window(pos_q, HIT_POS, GOOD_WIN);
  assign key_match = key_evt && (last_change == KEY);

  // An exit takes precedence over a press that arrives in the same cycle.
  assign miss    = active && (state_reg == LANE_ARMED) && !in_win;
  assign hit     = active && (state_reg == LANE_ARMED) && in_win && key_match;
  assign perfect = hit && (pos_q == HIT_POS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q     <= '0;
      state_reg <= LANE_IDLE;
    end else begin
      pos_q <= pos;
      if (!active) begin
        state_reg <= LANE_IDLE;
      end else begin
        case (state_reg)
          LANE_IDLE: begin
            if (in_win)
              state_reg <= LANE_ARMED;
          end
          LANE_ARMED: begin
            if (!in_win)
              state_reg <= LANE_IDLE;
            else if (key_match)
              state_reg <= LANE_LOCKED;
          end
          LANE_LOCKED: begin
            if (!in_win)
              state_reg <= LANE_IDLE;
          end
          default: state_reg <= LANE_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/hit_grader.sv
// Two-lane hit judge: merges lane events into hit/miss pulses, a grade and a combo.
// Define HIT_GRADER_COMBO_EN to build the combo counter; otherwise combo reads 0.
module hit_grader
  import hit_grader_pkg::*;
#(
  parameter logic [POS_W-1:0]   HIT_POS   = 5'd24,
  parameter int                 GOOD_WIN  = 2,
  parameter logic [CODE_W-1:0]  KEY_0     = 9'h023,
  parameter logic [CODE_W-1:0]  KEY_1     = 9'h042,
  parameter logic [COMBO_W-1:0] COMBO_MAX = 7'd99
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               active,
  input  logic               key_evt,
  input  logic [CODE_W-1:0]  last_change,
  input  logic [POS_W-1:0]   pos_0,
  input  logic [POS_W-1:0]   pos_1,
  output logic               hit_0,
  output logic               hit_1,
  output logic               miss,
  output logic [1:0]         grade,
  output logic [COMBO_W-1:0] combo
);

  localparam logic [POS_W-1:0]           GOOD_WIN_W = POS_W'(GOOD_WIN);
  localparam logic [1:0][CODE_W-1:0]     LANE_KEYS  = {KEY_1, KEY_0};

  logic [1:0][POS_W-1:0] lane_pos;
  logic [1:0]            lane_hit;
  logic [1:0]            lane_miss;
  logic [1:0]            lane_perfect;
  logic                  hit_any;
  logic                  miss_any;
  logic                  perfect_any;

  assign lane_pos = {pos_1, pos_0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    hit_lane #(
      .HIT_POS  (HIT_POS),
      .GOOD_WIN (GOOD_WIN_W),
      .KEY      (LANE_KEYS[gi])
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .active      (active),
      .key_evt     (key_evt),
      .last_change (last_change),
      .pos         (lane_pos[gi]),
      .hit         (lane_hit[gi]),
      .miss        (lane_miss[gi]),
      .perfect     (lane_perfect[gi])
    );
  end

  assign hit_any     = |lane_hit;
  assign miss_any    = |lane_miss;
  assign perfect_any = |lane_perfect;

  logic [1:0] hit_reg;
  logic       miss_reg;
  grade_t     grade_reg;

  // A miss anywhere outranks a hit on the other lane for the reported grade.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_reg   <= '0;
      miss_reg  <= 1'b0;
      grade_reg <= GRADE_NONE;
    end else if (!active) begin
      hit_reg   <= '0;
      miss_reg  <= 1'b0;
      grade_reg <= GRADE_NONE;
    end else begin
      hit_reg  <= lane_hit;
      miss_reg <= miss_any;
      if (miss_any)
        grade_reg <= GRADE_MISS;
      else if (hit_any)
        grade_reg <= perfect_any ? GRADE_PERFECT : GRADE_GOOD;
    end
  end

  assign hit_0 = hit_reg[0];
  assign hit_1 = hit_reg[1];
  assign miss  = miss_reg;
  assign grade = grade_reg;

`ifdef HIT_GRADER_COMBO_EN
  logic [COMBO_W-1:0] combo_reg;

  // A hit landing with a miss on the other lane restarts the streak at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      combo_reg <= '0;
    end else if (!active) begin
      combo_reg <= '0;
    end else if (miss_any) begin
      combo_reg <= hit_any ? COMBO_W'(1) : '0;
    end else if (hit_any && (combo_reg < COMBO_MAX)) begin
      combo_reg <= combo_reg + COMBO_W'(1);
    end
  end

  assign combo = combo_reg;
`else
  assign combo = '0;
`endif

endmodule

// File: tb/tb_hit_grader.sv
// Directed bench for hit_grader: a vector table walked one clock per row, then
// hand-written sequences for mid-pass reset and combo saturation.
module tb_hit_grader;

`ifdef HIT_GRADER_COMBO_EN
  localparam bit COMBO_ON = 1'b1;
`else
  localparam bit COMBO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       active = 1'b0;
  logic       key_evt = 1'b0;
  logic [8:0] last_change = '0;
  logic [4:0] pos_0 = '0;
  logic [4:0] pos_1 = '0;
  logic       hit_0, hit_1, miss;
  logic [1:0] grade;
  logic [6:0] combo;

  hit_grader dut (
    .clk         (clk),
    .rst         (rst),
    .active      (active),
    .key_evt     (key_evt),
    .last_change (last_change),
    .pos_0       (pos_0),
    .pos_1       (pos_1),
    .hit_0       (hit_0),
    .hit_1       (hit_1),
    .miss        (miss),
    .grade       (grade),
    .combo       (combo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       act;
    logic       kev;
    logic [8:0] code;
    logic [4:0] p0;
    logic [4:0] p1;
    logic       h0;
    logic       h1;
    logic       ms;
    logic [1:0] gr;
    logic [6:0] cb;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t v(input logic a, input logic k, input logic [8:0] code,
                             input logic [4:0] p0, input logic [4:0] p1,
                             input logic h0, input logic h1, input logic ms,
                             input logic [1:0] gr, input logic [6:0] cb);
    vec_t r;
    r.act = a; r.kev = k; r.code = code; r.p0 = p0; r.p1 = p1;
    r.h0 = h0; r.h1 = h1; r.ms = ms; r.gr = gr; r.cb = cb;
    return r;
  endfunction

  function automatic logic [11:0] expv(input logic h0, input logic h1, input logic ms,
                                       input logic [1:0] gr, input logic [6:0] cb);
    return {h0, h1, ms, gr, (COMBO_ON ? cb : 7'd0)};
  endfunction

  function automatic logic [11:0] outs();
    return {hit_0, hit_1, miss, grade, combo};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s h0=%b h1=%b miss=%b grade=%0d combo=%0d",
               name, act[11], act[10], act[9], act[8:7], act[6:0]);
    end else begin
      $display("FAIL %s got h0=%b h1=%b miss=%b grade=%0d combo=%0d need h0=%b h1=%b miss=%b grade=%0d combo=%0d",
               name, act[11], act[10], act[9], act[8:7], act[6:0],
               exp[11], exp[10], exp[9], exp[8:7], exp[6:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_c;

    // Lane 0 perfect hit, repeated press while locked, quiet exit.
    tbl.push_back(v(1,0,9'h000,20, 0, 0,0,0,0,0));
    tbl.push_back(v(1,0,9'h000,21, 0, 0,0,0,0,0));
    tbl.push_back(v(1,0,9'h000,22, 0, 0,0,0,0,0));
    tbl.push_back(v(1,0,9'h000,23, 0, 0,0,0,0,0));
    tbl.push_back(v(1,1,9'h011,24, 0, 0,0,0,0,0));
    tbl.push_back(v(1,1,9'h023,24, 0, 1,0,0,3,1));
    tbl.push_back(v(1,0,9'h023,24, 0, 0,0,0,3,1));
    tbl.push_back(v(1,1,9'h023,24, 0, 0,0,0,3,1));
    tbl.push_back(v(1,0,9'h000,27, 0, 0,0,0,3,1));
    tbl.push_back(v(1,0,9'h000, 0, 0, 0,0,0,3,1));
    // Lane 1 walks 22..27 unhit: one miss, combo cleared.
    tbl.push_back(v(1,0,9'h000, 0,22, 0,0,0,3,1));
    tbl.push_back(v(1,0,9'h000, 0,23, 0,0,0,3,1));
    tbl.push_back(v(1,0,9'h000, 0,24, 0,0,0,3,1));
    tbl.push_back(v(1,0,9'h000, 0,25, 0,0,0,3,1));
    tbl.push_back(v(1,0,9'h000, 0,26, 0,0,0,3,1));
    tbl.push_back(v(1,0,9'h000, 0,27, 0,0,0,3,1));
    tbl.push_back(v(1,0,9'h000, 0, 0, 0,0,1,1,0));
    tbl.push_back(v(1,0,9'h000, 0, 0, 0,0,0,1,0));
    // Lane 0 GOOD at 23, second press and wrong-lane press ignored.
    tbl.push_back(v(1,0,9'h000,23, 0, 0,0,0,1,0));
    tbl.push_back(v(1,0,9'h000,23, 0, 0,0,0,1,0));
    tbl.push_back(v(1,0,9'h023,23, 0, 0,0,0,1,0));
    tbl.push_back(v(1,1,9'h023,23, 0, 1,0,0,2,1));
    tbl.push_back(v(1,1,9'h023,23, 0, 0,0,0,2,1));
    tbl.push_back(v(1,1,9'h042,23, 0, 0,0,0,2,1));
    tbl.push_back(v(1,0,9'h000, 0, 0, 0,0,0,2,1));
    tbl.push_back(v(1,0,9'h000, 0, 0, 0,0,0,2,1));
    // Lane 1 GOOD, then lane 0 exits unhit while lane 1 is hit again.
    tbl.push_back(v(1,0,9'h000,24,26, 0,0,0,2,1));
    tbl.push_back(v(1,0,9'h000,24,26, 0,0,0,2,1));
    tbl.push_back(v(1,1,9'h042,24,26, 0,1,0,2,2));
    tbl.push_back(v(1,0,9'h000,24, 0, 0,0,0,2,2));
    tbl.push_back(v(1,0,9'h000,24,25, 0,0,0,2,2));
    tbl.push_back(v(1,0,9'h000,27,25, 0,0,0,2,2));
    tbl.push_back(v(1,1,9'h042, 0,25, 0,1,1,1,1));
    tbl.push_back(v(1,0,9'h000, 0, 0, 0,0,0,1,1));
    tbl.push_back(v(1,0,9'h000, 0, 0, 0,0,0,1,1));
    // Lane 1 perfect, re-arm, then active dropped while armed.
    tbl.push_back(v(1,0,9'h000, 0,24, 0,0,0,1,1));
    tbl.push_back(v(1,0,9'h000, 0,24, 0,0,0,1,1));
    tbl.push_back(v(1,1,9'h042, 0,24, 0,1,0,3,2));
    tbl.push_back(v(1,0,9'h000, 0, 0, 0,0,0,3,2));
    tbl.push_back(v(1,0,9'h000, 0, 0, 0,0,0,3,2));
    tbl.push_back(v(1,0,9'h000, 0,23, 0,0,0,3,2));
    tbl.push_back(v(1,0,9'h000, 0,23, 0,0,0,3,2));
    tbl.push_back(v(0,1,9'h042, 0,23, 0,0,0,0,0));
    tbl.push_back(v(1,0,9'h000, 0,23, 0,0,0,0,0));
    tbl.push_back(v(1,1,9'h042, 0,23, 0,1,0,2,1));

    repeat (2) @(posedge clk);
    #1;
    check("reset", outs(), expv(0,0,0,0,0));
    rst = 1'b0;

    foreach (tbl[i]) begin
      active      = tbl[i].act;
      key_evt     = tbl[i].kev;
      last_change = tbl[i].code;
      pos_0       = tbl[i].p0;
      pos_1       = tbl[i].p1;
      step();
      check($sformatf("row%0d", i), outs(),
            expv(tbl[i].h0, tbl[i].h1, tbl[i].ms, tbl[i].gr, tbl[i].cb));
    end

    // Asynchronous reset right after a hit pulse; enemy stays in the window.
    key_evt = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst", outs(), expv(0,0,0,0,0));
    step();
    rst = 1'b0;
    step();
    step();
    check("rearm_quiet", outs(), expv(0,0,0,0,0));
    key_evt = 1'b1;
    last_change = 9'h042;
    step();
    check("rearm_hit", outs(), expv(0,1,0,2,1));
    key_evt = 1'b0;
    pos_1 = 5'd0;

    // Back-to-back perfect passes on lane 0 until the combo saturates.
    exp_c = 1;
    for (int i = 0; i < 100; i++) begin
      pos_0 = 5'd24;
      step();
      step();
      key_evt = 1'b1;
      last_change = 9'h023;
      step();
      exp_c = (exp_c < 99) ? exp_c + 1 : 99;
      check($sformatf("sat%0d", i), outs(), expv(1,0,0,3,7'(exp_c)));
      key_evt = 1'b0;
      pos_0 = 5'd0;
      step();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
